// File: rtl/pulse_pkg.sv
// pulse_pkg -- shared definitions for the pulse generator family.
//   DEF_W          : default width of period, pulse-count and status counters
//   pulse_state_e  : train controller FSM encoding (IDLE / RUN / FINISH)
package pulse_pkg;

  localparam int DEF_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } pulse_state_e;

endpackage

// File: rtl/pulse_tick.sv
// pulse_tick -- period counter shared by the pulse generator family.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   en     : count enable; while low the counter is held at zero so every
//            enabled stretch starts from a clean phase
//   period : period P in cycles (must be non-zero while en is high)
//   tick   : combinational, high while the counter sits at P-1 with en high
// The counter runs 0..P-1 and wraps, so tick is high once every P cycles.
module pulse_tick
  import pulse_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] last_val;

  assign last_val = period - W'(1);
  assign tick     = en && (cnt_q == last_val);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/pulse_train_ctrl.sv
// pulse_train_ctrl -- launches a train of one-cycle pulses, one per period.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, beats start/stop
//   start_i  : launch request, level-sampled every edge (only acted on in IDLE)
//   stop_i   : abort request, level-sampled every edge; beats start and pulses
//   period_i : period P, captured when a start is accepted (0 is rejected)
//   num_i    : pulse count N, captured on acceptance; 0 means free-run
//   pulse_o  : one-cycle pulse every P cycles while running
//   busy_o   : high while a train is running
//   done_o   : one-cycle strobe after the Nth pulse of a finite train
//   err_o    : one-cycle strobe when a start is rejected for period_i == 0
//   sent_o   : pulses emitted in the current / last train (wraps mod 2^W)
//   state_o  : FSM state, exposed for debug
// Control inputs are plain levels; there is no handshake. Every output comes
// straight from a flop: the always_comb block computes next values and the
// always_ff block registers them.
module pulse_train_ctrl
  import pulse_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic [W-1:0] period_i,
  input  logic [W-1:0] num_i,
  output logic         pulse_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [W-1:0] sent_o,
  output pulse_state_e state_o
);

  pulse_state_e state_n;
  logic [W-1:0] period_q, period_n;
  logic [W-1:0] num_q, num_n;
  logic [W-1:0] sent_n;
  logic [W-1:0] sent_inc;
  logic         pulse_n, busy_n, done_n, err_n;
  logic         tick;

  // Counter is enabled only in RUN; it is zero on the acceptance edge, so
  // the first tick (and hence the first registered pulse) lands P cycles later.
  pulse_tick #(.W(W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (state_o == RUN),
    .period (period_q),
    .tick   (tick)
  );

  assign sent_inc = sent_o + W'(1);

  always_comb begin
    state_n  = state_o;
    period_n = period_q;
    num_n    = num_q;
    sent_n   = sent_o;
    busy_n   = busy_o;
    pulse_n  = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state_o)
      IDLE: begin
        busy_n = 1'b0;
        if (start_i && !stop_i) begin
          if (period_i == '0) begin
            err_n = 1'b1;
          end else begin
            period_n = period_i;
            num_n    = num_i;
            sent_n   = '0;
            busy_n   = 1'b1;
            state_n  = RUN;
          end
        end
      end
      RUN: begin
        if (stop_i) begin
          // Abort: a pulse due on this edge is dropped, count is kept.
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (tick) begin
          pulse_n = 1'b1;
          sent_n  = sent_inc;
          if (num_q != '0 && sent_inc == num_q) begin
            state_n = FINISH;
          end
        end
      end
      FINISH: begin
        // busy stays high through the last pulse and drops with done.
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_o  <= IDLE;
      period_q <= '0;
      num_q    <= '0;
      sent_o   <= '0;
      pulse_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state_o  <= state_n;
      period_q <= period_n;
      num_q    <= num_n;
      sent_o   <= sent_n;
      pulse_o  <= pulse_n;
      busy_o   <= busy_n;
      done_o   <= done_n;
      err_o    <= err_n;
    end
  end

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// tb_pulse_train_ctrl -- directed bench for pulse_train_ctrl (W = 8).
// Cycle k of a train is the clock period following the k-th rising edge
// after the acceptance edge (edge 0). Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_pulse_train_ctrl;
  import pulse_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start_i, stop_i;
  logic [W-1:0] period_i, num_i;
  logic         pulse_o, busy_o, done_o, err_o;
  logic [W-1:0] sent_o;
  pulse_state_e state_o;

  always #5 clk = ~clk;

  pulse_train_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .stop_i   (stop_i),
    .period_i (period_i),
    .num_i    (num_i),
    .pulse_o  (pulse_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .sent_o   (sent_o),
    .state_o  (state_o)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a start for one edge (edge 0); returns in cycle 0 with start low.
  task automatic launch(input logic [W-1:0] p, input logic [W-1:0] n);
    start_i  = 1'b1;
    period_i = p;
    num_i    = n;
    step();
    start_i  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pulse"}, 32'(pulse_o), 0);
    check({tag, "_busy"},  32'(busy_o),  0);
    check({tag, "_done"},  32'(done_o),  0);
    check({tag, "_err"},   32'(err_o),   0);
    check({tag, "_sent"},  32'(sent_o),  0);
    check({tag, "_state"}, 32'(state_o), 32'(IDLE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] e;
    rst      = 1'b1;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    period_i = '0;
    num_i    = '0;
    step();
    step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();

    // P=4, N=3: pulses at 4, 8, 12; done at 13; inputs changed after accept.
    launch(8'd4, 8'd3);
    period_i = 8'd1;
    num_i    = 8'd1;
    check("t1_busy0", 32'(busy_o), 1);
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("t1_pulse[%0d]", k), 32'(pulse_o), 32'(k == 4 || k == 8 || k == 12));
      check($sformatf("t1_done[%0d]", k),  32'(done_o),  32'(k == 13));
      check($sformatf("t1_busy[%0d]", k),  32'(busy_o),  32'(k <= 12));
      check($sformatf("t1_sent[%0d]", k),  32'(sent_o),
            (k >= 12) ? 3 : (k >= 8) ? 2 : (k >= 4) ? 1 : 0);
    end

    // P=1, N=0: pulse every cycle 1..10, stop during cycle 10.
    launch(8'd1, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("t2_pulse[%0d]", k), 32'(pulse_o), 1);
      check($sformatf("t2_sent[%0d]", k),  32'(sent_o),  k);
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    check("t2_stop_pulse", 32'(pulse_o), 0);
    check("t2_stop_busy",  32'(busy_o),  0);
    check("t2_stop_sent",  32'(sent_o),  10);
    check("t2_stop_done",  32'(done_o),  0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_after_pulse", 32'(pulse_o), 0);
      check("t2_after_done",  32'(done_o),  0);
      check("t2_after_sent",  32'(sent_o),  10);
    end

    // Rejected start (period 0), then start+stop together.
    launch(8'd0, 8'd3);
    check("t3_err",   32'(err_o),   1);
    check("t3_busy",  32'(busy_o),  0);
    check("t3_state", 32'(state_o), 32'(IDLE));
    step();
    check("t3_err_clr", 32'(err_o), 0);
    start_i  = 1'b1;
    stop_i   = 1'b1;
    period_i = 8'd5;
    num_i    = 8'd2;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t3_ss_busy",  32'(busy_o),  0);
      check("t3_ss_pulse", 32'(pulse_o), 0);
      check("t3_ss_err",   32'(err_o),   0);
    end
    start_i = 1'b0;
    stop_i  = 1'b0;

    // P=3, N=5 with reset during cycle 7; then a fresh P=3, N=1 train.
    launch(8'd3, 8'd5);
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("t4_pulse[%0d]", k), 32'(pulse_o), 32'(k == 3 || k == 6));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("t4_rst");
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_quiet_pulse", 32'(pulse_o), 0);
      check("t4_quiet_busy",  32'(busy_o),  0);
    end
    launch(8'd3, 8'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("t4b_pulse[%0d]", k), 32'(pulse_o), 32'(k == 3));
      check($sformatf("t4b_done[%0d]", k),  32'(done_o),  32'(k == 4));
      check($sformatf("t4b_sent[%0d]", k),  32'(sent_o),  32'(k >= 3));
      check($sformatf("t4b_busy[%0d]", k),  32'(busy_o),  32'(k <= 3));
    end

    // Back-to-back P=2, N=2 with start held: second accept on edge 6.
    start_i  = 1'b1;
    period_i = 8'd2;
    num_i    = 8'd2;
    step();
    check("t5_busy0", 32'(busy_o), 1);
    for (int k = 1; k <= 11; k++) begin
      step();
      check($sformatf("t5_pulse[%0d]", k), 32'(pulse_o),
            32'(k == 2 || k == 4 || k == 8 || k == 10));
      check($sformatf("t5_done[%0d]", k), 32'(done_o), 32'(k == 5 || k == 11));
      check($sformatf("t5_busy[%0d]", k), 32'(busy_o), 32'(k != 5 && k != 11));
      if (k == 6) check("t5_sent_clr", 32'(sent_o), 0);
      if (k == 8) check("t5_sent_b1",  32'(sent_o), 1);
    end
    start_i = 1'b0;
    step();
    check("t5_no_reaccept", 32'(busy_o), 0);

    // P=255 free-run for 600 cycles with noisy start/period/num.
    launch(8'd255, 8'd0);
    exp_q.push_back(16'd255);
    exp_q.push_back(16'd510);
    for (int k = 1; k <= 600; k++) begin
      start_i  = 1'($urandom_range(0, 1));
      period_i = 8'($urandom_range(1, 20));
      num_i    = 8'($urandom_range(1, 5));
      step();
      if (pulse_o) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'd0;
        check("t6_pulse_cycle", k, 32'(e));
      end
    end
    start_i = 1'b0;
    check("t6_missing_pulses", exp_q.size(), 0);
    check("t6_sent", 32'(sent_o), 2);
    check("t6_busy", 32'(busy_o), 1);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    check("t6_stop_busy", 32'(busy_o), 0);
    check("t6_stop_sent", 32'(sent_o), 2);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_train_ctrl.md
PULSE_TRAIN_CTRL -- requirements
Module: pulse_train_ctrl

Interface
REQ-001 Parameter: W, default 8, width of period, pulse-count and status counters.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  request to launch a pulse train; level-sampled each edge.
REQ-005 stop_i  input  1  abort request; level-sampled each edge.
REQ-006 period_i  input  W  pulse period in cycles, captured on start acceptance.
REQ-007 num_i  input  W  pulses to emit, captured on start acceptance; 0 = free-run until stop.
REQ-008 pulse_o  output  1  one-cycle-wide pulse per period.
REQ-009 busy_o  output  1  high while a train is running.
REQ-010 done_o  output  1  one-cycle strobe on normal completion.
REQ-011 err_o  output  1  one-cycle strobe on rejected start (period_i == 0).
REQ-012 sent_o  output  W  pulses emitted in the current/last train.

Function
REQ-013 FSM SHALL have states IDLE, RUN, FINISH; reset state IDLE.
REQ-014 IDLE: start_i=1, stop_i=0, period_i!=0 -> capture period_i/num_i, clear period counter and sent_o, go to RUN; busy_o high from the next cycle.
REQ-015 IDLE: start_i=1 with period_i==0 -> stay IDLE, err_o high one cycle, nothing captured.
REQ-016 IDLE: start_i and stop_i both high -> stop wins, start ignored, no err_o.
REQ-017 RUN: period counter counts 0..P-1 and wraps; pulse_o SHALL be registered and high exactly in the cycle after the counter reaches P-1.
REQ-018 Latency: with acceptance edge at cycle 0, pulses SHALL be high in cycles P, 2P, 3P, ...; P=1 gives pulse_o high every cycle from cycle 1.
REQ-019 sent_o SHALL increment in the same cycle pulse_o is high; with num_i=0 it wraps modulo 2^W with no other effect.
REQ-020 RUN, num_i=N!=0: after the Nth pulse -> FINISH; no further pulses.
REQ-021 FINISH: done_o high for exactly one cycle (cycle N*P+1), busy_o low in that cycle, then IDLE.
REQ-022 RUN: stop_i=1 -> IDLE on that edge; pulse_o, busy_o low next cycle; no done_o; sent_o holds count reached; stop wins over a coincident pulse (pulse suppressed).
REQ-023 start_i in RUN or FINISH SHALL be ignored; changes to period_i/num_i after acceptance SHALL have no effect.
REQ-024 A new start may be accepted in IDLE the cycle after FINISH (back-to-back trains).
REQ-025 Counter arithmetic SHALL be W-bit unsigned; P=2^W-1 and N=2^W-1 are legal.

Reset
REQ-026 rst high at any edge, including mid-train, SHALL force IDLE, pulse_o=0, busy_o=0, done_o=0, err_o=0, sent_o=0, internal counters 0.
REQ-027 rst SHALL take priority over start_i and stop_i; a start sampled in the reset cycle is lost.

Structure
REQ-028 Shared package pulse_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, FINISH=2'd2) and default W.
REQ-029 Period counting SHALL live in one sub-module pulse_tick (inputs clk, rst, en, period; output tick), reused by the existing pulse generator family.
REQ-030 All outputs SHALL be driven directly from flops.

Verification
REQ-031 Reset, then start at cycle 0 with P=4, N=3 -> pulse_o in cycles 4, 8, 12; sent_o 1,2,3; done_o in cycle 13; busy_o low from cycle 13.
REQ-032 P=1, N=0, stop_i at cycle 10 -> pulse_o high cycles 1..10, low from 11; sent_o=10; no done_o.
REQ-033 period_i=0 with start_i -> err_o one cycle, busy_o stays 0; start+stop together with P=5 -> no activity.
REQ-034 P=3, N=5, rst pulsed at cycle 7 -> all outputs 0 at cycle 8; no further pulses; next start behaves as fresh train.
REQ-035 Back-to-back: P=2, N=2 then start held high -> second train accepted cycle after done_o, its pulses at +2, +4.
REQ-036 W=8, P=255, N=0 run 600 cycles -> pulse_o exactly at multiples of 255; start_i toggled during RUN and period_i changed have no effect.
